// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
// Multi-cycle restoring divider that owns the single DIV/DIVU resource of the
// EX stage. It accepts one request, runs DW shift/subtract steps on operand
// magnitudes, then applies the sign correction and presents
// {remainder, quotient} for HI/LO. While the request is in progress it asks
// ctrl to stall the pipeline. The in-flight request can be annulled.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   signed_div_i  1 = DIV (signed), 0 = DIVU
//   opdata1_i     dividend (rs), DW bits
//   opdata2_i     divisor (rt), DW bits
//   start_i       request, held high by EX until ready_o is seen
//   annul_i       cancel the in-flight request (flush / exception)
//   result_o      {remainder, quotient}, 2*DW bits
//   ready_o       result_o is valid
//   stallreq_o    pipeline stall request to ctrl
// -----------------------------------------------------------------------------
module div_seq #(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_div_i,
    input  logic [DW-1:0]     opdata1_i,
    input  logic [DW-1:0]     opdata2_i,
    input  logic              start_i,
    input  logic              annul_i,
    output logic [2*DW-1:0]   result_o,
    output logic              ready_o,
    output logic              stallreq_o
);

    typedef enum logic [1:0] {
        FREE = 2'd0,
        DIVZ = 2'd1,
        ON   = 2'd2,
        END  = 2'd3
    } state_t;

    localparam logic [DW-1:0]    ONE      = DW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DW-1:0]      dividend;
    logic [DW-1:0]      divisor;
    logic [DW-1:0]      rem;
    logic [DW-1:0]      quo;
    logic               neg_q;
    logic               neg_r;

    // Magnitudes of the incoming operands. For DIV a negative value is
    // replaced by its two's complement; the most negative value maps onto
    // itself, which is exactly its unsigned magnitude.
    logic               op1_neg;
    logic               op2_neg;
    logic [DW-1:0]      mag1;
    logic [DW-1:0]      mag2;

    assign op1_neg = signed_div_i & opdata1_i[DW-1];
    assign op2_neg = signed_div_i & opdata2_i[DW-1];
    assign mag1    = op1_neg ? (~opdata1_i + ONE) : opdata1_i;
    assign mag2    = op2_neg ? (~opdata2_i + ONE) : opdata2_i;

    // One restoring step: shift the next dividend bit into the partial
    // remainder. Because rem < divisor, the shifted value needs one extra bit,
    // but when it is >= divisor the difference again fits in DW bits.
    logic [DW:0]        shifted;
    logic               take;
    logic [DW-1:0]      sub;

    assign shifted = {rem, dividend[DW-1]};
    assign take    = (shifted >= {1'b0, divisor});
    assign sub     = shifted[DW-1:0] - divisor;

    // Sign correction applied once all steps are done.
    logic [DW-1:0]      quo_fix;
    logic [DW-1:0]      rem_fix;

    assign quo_fix = neg_q ? (~quo + ONE) : quo;
    assign rem_fix = neg_r ? (~rem + ONE) : rem;

    // Low in END so that EX can consume the result on that cycle.
    assign stallreq_o = start_i & ~ready_o;

    // Sequencer: capture, DW steps, fix-up, then hold the result until EX
    // drops start_i.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FREE;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= DIVZ;
                        end else begin
                            state    <= ON;
                            cnt      <= '0;
                            dividend <= mag1;
                            divisor  <= mag2;
                            rem      <= '0;
                            quo      <= '0;
                            neg_q    <= op1_neg ^ op2_neg;
                            neg_r    <= op1_neg;
                        end
                    end
                end
                DIVZ: begin
                    result_o <= '0;
                    ready_o  <= 1'b1;
                    state    <= END;
                end
                ON: begin
                    if (annul_i) begin
                        state <= FREE;
                        cnt   <= '0;
                    end else if (cnt != CNT_LAST) begin
                        rem      <= take ? sub : shifted[DW-1:0];
                        quo      <= {quo[DW-2:0], take};
                        dividend <= {dividend[DW-2:0], 1'b0};
                        cnt      <= cnt + CNT_ONE;
                    end else begin
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= 1'b1;
                        cnt      <= '0;
                        state    <= END;
                    end
                end
                END: begin
                    if (!start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                        state    <= FREE;
                    end
                end
                default: begin
                    state <= FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq
// Scoreboard bench for div_seq. The driver issues requests and pushes the
// expected {remainder, quotient} and the cycle on which ready_o must first be
// seen; an independent monitor pops and compares whenever ready_o rises, and
// checks result stability in END and the stall request every cycle.
// -----------------------------------------------------------------------------
module tb_div_seq;

    localparam int DW = 32;

    logic              clk;
    logic              rst;
    logic              signed_div_i;
    logic [DW-1:0]     opdata1_i;
    logic [DW-1:0]     opdata2_i;
    logic              start_i;
    logic              annul_i;
    logic [2*DW-1:0]   result_o;
    logic              ready_o;
    logic              stallreq_o;

    div_seq #(.DW(DW), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;

    // Free-running edge counter used to check latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain integer division, truncating toward zero, with
    // the remainder taking the dividend's sign. 64-bit arithmetic keeps the
    // most-negative / -1 case well defined.
    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
        longint la;
        longint lb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'd0, a});
            lb = longint'({32'd0, b});
        end
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: independent of the driver, pops one entry per ready_o rise.
    exp_t        mon_e;
    logic        ready_q = 1'b0;
    logic [63:0] held = 64'd0;

    always @(negedge clk) begin
        if (!rst) begin
            ready_q = 1'b0;
        end else begin
            checkOutput("stallreq", {63'd0, stallreq_o}, {63'd0, start_i & ~ready_o});
            if (ready_o && !ready_q) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_ready: got result %h, expected no result", result_o);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("result", result_o, mon_e.res);
                    checkOutput("latency", 64'(cyc), 64'(mon_e.due));
                end
                held = result_o;
            end else if (ready_o) begin
                checkOutput("stable", result_o, held);
            end
            ready_q = ready_o;
        end
    end

    // Inputs change just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitDone();
        int k;
        k = 0;
        while (!ready_o && k < 40) begin
            tick();
            k++;
        end
        if (!ready_o) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL timeout: got ready_o=0 after %0d cycles, expected 1", k);
            rst = 1'b0;
            start_i = 1'b0;
            tick();
            rst = 1'b1;
            sb.delete();
            tick();
        end
    endtask

    // Issue one request, scramble the operands once captured, wait for the
    // result, hold start_i in END for 'hold' extra cycles, then release.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic sgn, input int hold);
        exp_t e;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        e.res = refDiv(a, b, sgn);
        e.due = cyc + ((b == 32'd0) ? 2 : 34);
        sb.push_back(e);
        tick();
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
        waitDone();
        repeat (hold) tick();
        start_i = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        rst          = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;

        #12;
        checkOutput("reset_result", result_o, 64'd0);
        checkOutput("reset_ready", {63'd0, ready_o}, 64'd0);
        checkOutput("reset_stall", {63'd0, stallreq_o}, 64'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("[TB] directed divisions");
        applyStimulus(32'd100, 32'd7, 1'b0, 2);
        applyStimulus(32'hFFFFFF9C, 32'd7, 1'b1, 0);
        applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b1, 1);
        applyStimulus(32'd7, 32'hFFFFFFFE, 1'b1, 0);
        applyStimulus(32'h80000000, 32'd2, 1'b1, 0);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
        applyStimulus(32'd123, 32'd0, 1'b0, 1);
        applyStimulus(32'hFFFFFFFB, 32'd0, 1'b1, 0);

        $display("[TB] annul while idle is ignored");
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        repeat (3) tick();
        checkOutput("annul_free_ready", {63'd0, ready_o}, 64'd0);
        applyStimulus(32'd50, 32'd5, 1'b0, 0);

        $display("[TB] annul at cnt=10 then immediate DIVU 9/3");
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd7;
        signed_div_i = 1'b0;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        tick();
        repeat (10) tick();
        annul_i = 1'b1;
        tick();
        checkOutput("annul_ready", {63'd0, ready_o}, 64'd0);
        applyStimulus(32'd9, 32'd3, 1'b0, 0);

        $display("[TB] async reset mid-division");
        opdata1_i    = 32'd77777;
        opdata2_i    = 32'd13;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        tick();
        repeat (20) tick();
        #2;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        checkOutput("rst_on_result", result_o, 64'd0);
        checkOutput("rst_on_ready", {63'd0, ready_o}, 64'd0);
        checkOutput("rst_on_stall", {63'd0, stallreq_o}, 64'd0);
        tick();
        rst = 1'b1;
        tick();
        applyStimulus(32'd1000, 32'd3, 1'b0, 3);

        $display("[TB] async reset while result is held");
        begin
            exp_t e;
            opdata1_i    = 32'd1001;
            opdata2_i    = 32'd10;
            signed_div_i = 1'b0;
            start_i      = 1'b1;
            e.res = refDiv(32'd1001, 32'd10, 1'b0);
            e.due = cyc + 34;
            sb.push_back(e);
            tick();
            waitDone();
            tick();
            #2;
            rst     = 1'b0;
            start_i = 1'b0;
            #1;
            checkOutput("rst_end_result", result_o, 64'd0);
            checkOutput("rst_end_ready", {63'd0, ready_o}, 64'd0);
            tick();
            rst = 1'b1;
            tick();
        end

        $display("[TB] randomized divisions");
        for (int i = 0; i < 40; i++) begin
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            else if (sel < 3) b = 32'($urandom_range(1, 255));
            else if (sel == 3) b = -32'($urandom_range(1, 255));
            else if (sel == 4) a = 32'h80000000;
            applyStimulus(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        repeat (2) tick();
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL leftover: got %0d pending results, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
